data_mem_responder: RTL and testbench

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests (mem_read, mem_write, address, write_data). It holds a word-addressed backing store and models a configurable access latency. It asserts stall so the pipeline freezes until each access completes. It returns load data on read_data, which feeds the MEM/WB register.

---
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for MEM-stage loads/stores with pipeline stall.
// Optional macro DMEM_ZERO_WAIT_EN: bypass the FSM for single-cycle combinational access.
module data_mem_responder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              resp_valid,
    output logic              misaligned
);
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W  = 4;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              req;
    logic [WIDX_W-1:0] widx;
    logic [IDX_W-1:0]  idx;
    logic              widx_ok;

    assign req     = mem_read | mem_write;
    assign idx     = widx[IDX_W-1:0];
    assign widx_ok = (widx < WIDX_W'(DEPTH_WORDS));
    assign wr_idx  = idx;

    // Backing store: cleared by reset, written by the selected access path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

`ifdef DMEM_ZERO_WAIT_EN

    assign widx       = address[ADDR_W-1:2];
    assign wr_en      = mem_write & widx_ok;
    assign wr_data    = write_data;
    assign stall      = 1'b0;
    assign resp_valid = req;
    assign misaligned = req & (address[1:0] != 2'b00);
    assign read_data  = widx_ok ? mem_q[idx] : '0;

`else

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_rd_q, op_rd_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              misaligned_q, misaligned_d;

    assign widx       = addr_q[ADDR_W-1:2];
    assign wr_data    = wdata_q;
    assign read_data  = rdata_q;
    assign resp_valid = resp_valid_q;
    assign misaligned = misaligned_q;

    // Next-state, stall and access strobes; the access happens on the BUSY->DONE edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_rd_d      = op_rd_q;
        op_wr_d      = op_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        misaligned_d = 1'b0;
        wr_en        = 1'b0;
        stall        = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = req & ~rst;
                if (req) begin
                    op_rd_d = mem_read;
                    op_wr_d = mem_write;
                    addr_d  = address;
                    wdata_d = write_data;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    misaligned_d = (addr_q[1:0] != 2'b00);
                    wr_en        = op_wr_q & widx_ok;
                    if (op_rd_q) begin
                        rdata_d = widx_ok ? mem_q[idx] : '0;
                    end
                end
            end
            S_DONE: begin
                // Request still held by the completing instruction is ignored here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_rd_q      <= 1'b0;
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_rd_q      <= op_rd_d;
            op_wr_q      <= op_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, reset sequences, random model check.
module tb_data_mem_responder;
    localparam int unsigned LAT = 3;
    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        resp_valid;
    logic        misaligned;

    int errors;
    int checks;

    data_mem_responder #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .stall(stall), .resp_valid(resp_valid), .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          hold;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [15];

    // Reference model: plain word array plus last load result.
    logic [31:0] mem_m [DEPTH];
    logic [31:0] rdata_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 32'h0;
        rdata_m = 32'h0;
    endtask

    task automatic model_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] exp_rd, output logic exp_mis);
        int unsigned w;
        logic [31:0] old;
        w = int'(a >> 2);
        old = (w < DEPTH) ? mem_m[w] : 32'h0;
        if (rd) rdata_m = old;
        if (wr && (w < DEPTH)) mem_m[w] = d;
        exp_rd  = rdata_m;
        exp_mis = (a % 4) != 0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("stall_idle", 32'(stall), 32'd1 - 32'd1);
        chk("resp_idle", 32'(resp_valid), 32'd0);
    endtask

    // One full access: request cycle, LAT busy cycles with scrambled inputs, then the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, input logic [31:0] exp_rd, input logic exp_mis);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; address = a; write_data = d;
        @(negedge clk);
        chk("stall_req", 32'(stall), 32'd1);
        chk("resp_req", 32'(resp_valid), 32'd0);
        for (int c = 1; c <= int'(LAT); c++) begin
            @(posedge clk); #1;
            mem_read   = 1'($urandom);
            mem_write  = 1'($urandom);
            address    = $urandom;
            write_data = $urandom;
            @(negedge clk);
            chk("stall_busy", 32'(stall), 32'd1);
            chk("resp_busy", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        if (hold) begin
            mem_read = rd; mem_write = wr; address = a; write_data = d;
        end else begin
            mem_read = 1'b0; mem_write = 1'b0;
        end
        @(negedge clk);
        chk("stall_done", 32'(stall), 32'd0);
        chk("resp_done", 32'(resp_valid), 32'd1);
        chk("mis_done", 32'(misaligned), 32'(exp_mis));
        chk("rdata_done", read_data, exp_rd);
    endtask

    initial begin
        logic [31:0] er;
        logic        em;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        int unsigned op;
        int unsigned sel;

        errors = 0;
        checks = 0;

        vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h10,   32'h11111111, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h14,   32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'h11111111, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h14,   32'h0,        1'b0, 32'h12345678, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h1000, 32'hAAAAAAAA, 1'b0, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h13,   32'hCAFEF00D, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'h14,   32'h55555555, 1'b0, 32'h12345678, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h14,   32'h0,        1'b0, 32'h55555555, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h1002, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'h12,   32'h0,        1'b0, 32'hCAFEF00D, 1'b1};

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = 32'h0; write_data = 32'h0;
        #12;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_resp", 32'(resp_valid), 32'd0);
        chk("reset_rdata", read_data, 32'h0);
        chk("reset_mis", 32'(misaligned), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        foreach (vecs[i]) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].hold, vecs[i].exp_rd, vecs[i].exp_mis);
        end
        idle_cycle();

        // Store to 0x20, reset mid-cycle while BUSY with the request still driven.
        @(posedge clk); #1;
        mem_write = 1'b1; address = 32'h20; write_data = 32'h87654321;
        @(negedge clk);
        chk("rst_seq_stall_req", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_seq_stall_busy", 32'(stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_stall", 32'(stall), 32'd0);
        chk("rst_async_resp", 32'(resp_valid), 32'd0);
        chk("rst_async_rdata", read_data, 32'h0);
        @(negedge clk);
        mem_write = 1'b0;
        rst = 1'b0;
        model_reset();
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            op  = $urandom_range(1, 3);
            rd  = op[0];
            wr  = op[1];
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h1000 + 32'($urandom_range(0, 255));
            else if (sel == 1) a = $urandom;
            else               a = 32'($urandom_range(0, 63));
            d = $urandom;
            model_op(rd, wr, a, d, er, em);
            access(rd, wr, a, d, 1'($urandom), er, em);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
